// File: rtl/fa_using_nand.sv
// Single-bit full adder with combinational sum/cout and a registered copy of both.
// Define FA_USING_NAND_STRUCT_EN to build the core from nine explicit 2-input NAND gates.

`ifdef FA_USING_NAND_STRUCT_EN
module fa_using_nand_nand2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a & i_b);
endmodule
`endif

module fa_using_nand (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q
);

    logic w_sum;
    logic w_cout;
    logic r_sum_q;
    logic r_cout_q;

`ifdef FA_USING_NAND_STRUCT_EN
    logic w_n1;
    logic w_n2;
    logic w_n3;
    logic w_x;
    logic w_n5;
    logic w_n6;
    logic w_n7;

    // First half adder: w_x = a ^ b, w_n1 doubles as the inverted a&b term.
    fa_using_nand_nand2 u_n1   (.i_a(a),    .i_b(b),    .o_y(w_n1));
    fa_using_nand_nand2 u_n2   (.i_a(a),    .i_b(w_n1), .o_y(w_n2));
    fa_using_nand_nand2 u_n3   (.i_a(b),    .i_b(w_n1), .o_y(w_n3));
    fa_using_nand_nand2 u_x    (.i_a(w_n2), .i_b(w_n3), .o_y(w_x));
    fa_using_nand_nand2 u_n5   (.i_a(w_x),  .i_b(cin),  .o_y(w_n5));
    fa_using_nand_nand2 u_n6   (.i_a(w_x),  .i_b(w_n5), .o_y(w_n6));
    fa_using_nand_nand2 u_n7   (.i_a(cin),  .i_b(w_n5), .o_y(w_n7));
    fa_using_nand_nand2 u_sum  (.i_a(w_n6), .i_b(w_n7), .o_y(w_sum));
    fa_using_nand_nand2 u_cout (.i_a(w_n1), .i_b(w_n5), .o_y(w_cout));
`else
    assign w_sum  = a ^ b ^ cin;
    assign w_cout = (a & b) | (cin & (a ^ b));
`endif

    assign sum  = w_sum;
    assign cout = w_cout;

    // Pipeline copy of the adder result; cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q  <= 1'b0;
            r_cout_q <= 1'b0;
        end else begin
            r_sum_q  <= w_sum;
            r_cout_q <= w_cout;
        end
    end

    assign sum_q  = r_sum_q;
    assign cout_q = r_cout_q;

endmodule

// File: tb/tb_fa_using_nand.sv
// Directed self-checking bench for fa_using_nand: truth-table sweep, latency and reset behaviour.

module tb_fa_using_nand;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic sum_q;
    logic cout_q;

    int n_pass;
    int n_total;

    // Hand-computed {cout,sum} for {a,b,cin} = 000 .. 111
    logic [1:0] exp_tab [8];

    fa_using_nand dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    initial begin
        logic [2:0] v;
        n_pass  = 0;
        n_total = 0;
        exp_tab[0] = 2'b00; exp_tab[1] = 2'b01; exp_tab[2] = 2'b01; exp_tab[3] = 2'b10;
        exp_tab[4] = 2'b01; exp_tab[5] = 2'b10; exp_tab[6] = 2'b10; exp_tab[7] = 2'b11;

        rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0;
        #3;
        check("reset_sum_q",  sum_q,  1'b0);
        check("reset_cout_q", cout_q, 1'b0);

        // Exhaustive sweep while held in reset: comb outputs track, registers stay clear
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = 3'(i);
            {a, b, cin} = v;
            #1;
            check($sformatf("sweep_sum_%b", v),  sum,  exp_tab[i][0]);
            check($sformatf("sweep_cout_%b", v), cout, exp_tab[i][1]);
            check($sformatf("sweep_sumq_rst_%b", v), sum_q, 1'b0);
        end
        @(posedge clk); #1;
        check("rst_hold_cout_q", cout_q, 1'b0);

        // Registered latency: 101 captured on first edge after release
        @(negedge clk);
        rst = 1'b0; a = 1'b1; b = 1'b0; cin = 1'b1;
        #1;
        check("pre_edge_sum_q",  sum_q,  1'b0);
        check("pre_edge_cout_q", cout_q, 1'b0);
        @(posedge clk); #1;
        check("lat_101_sum_q",  sum_q,  1'b0);
        check("lat_101_cout_q", cout_q, 1'b1);
        #2;
        a = 1'b0; b = 1'b0; cin = 1'b0;
        #1;
        check("mid_000_sum",    sum,    1'b0);
        check("mid_000_cout",   cout,   1'b0);
        check("hold_cout_q",    cout_q, 1'b1);
        check("hold_sum_q",     sum_q,  1'b0);
        @(posedge clk); #1;
        check("lat_000_sum_q",  sum_q,  1'b0);
        check("lat_000_cout_q", cout_q, 1'b0);

        // Further captures: 011 -> 1/0, 100 -> 0/1
        @(negedge clk);
        a = 1'b0; b = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        check("lat_011_sum_q",  sum_q,  1'b0);
        check("lat_011_cout_q", cout_q, 1'b1);
        @(negedge clk);
        a = 1'b1; b = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        check("lat_100_sum_q",  sum_q,  1'b1);
        check("lat_100_cout_q", cout_q, 1'b0);

        // Asynchronous reset between edges after capturing 111
        @(negedge clk);
        a = 1'b1; b = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        check("lat_111_sum_q",  sum_q,  1'b1);
        check("lat_111_cout_q", cout_q, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sum_q",  sum_q,  1'b0);
        check("async_rst_cout_q", cout_q, 1'b0);
        check("async_rst_sum",    sum,    1'b1);
        check("async_rst_cout",   cout,   1'b1);
        @(posedge clk); #1;
        check("rst_held_sum_q", sum_q, 1'b0);

        // Release with 010 held: first capture only on the next rising edge
        @(negedge clk);
        a = 1'b0; b = 1'b1; cin = 1'b0;
        rst = 1'b0;
        #1;
        check("release_sum_q",  sum_q,  1'b0);
        check("release_cout_q", cout_q, 1'b0);
        @(posedge clk); #1;
        check("release_cap_sum_q",  sum_q,  1'b1);
        check("release_cap_cout_q", cout_q, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
